i2c_burst_master: RTL and testbench

I2C_BURST_MASTER -- requirements
Module: i2c_burst_master

---
 rtl/i2c_burst_master.sv | 177 +++++++++++++++++
 tb/tb_i2c_burst_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_burst_master.sv
// I2C master issuing START, 7-bit address, a burst of 0..2^LEN_W-1 data bytes and STOP.
// The bit slot is four quarter ticks: SCL low in q0-q1, released in q2-q3, SDA sampled at the end of q2.
module i2c_burst_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       addr,
  input  logic             rw,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       tx_data,
  output logic             tx_ack,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             ack_err,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             sda_i
);

  localparam int unsigned QW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_STOP, S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [QW-1:0]    qcnt;
  logic [1:0]       q;
  logic [2:0]       bit_cnt;
  logic [7:0]       sh;
  logic [LEN_W-1:0] rem;
  logic             rw_q;
  logic             ack_smp;
  logic             tick, slot_end, samp;

  assign tick     = (qcnt == QW'(CLK_DIV - 1));
  assign slot_end = tick && (q == 2'd3);
  assign samp     = tick && (q == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    scl_oe   = 1'b0;
    sda_oe   = 1'b0;
    tx_ack   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_START;
      end
      S_START: begin
        sda_oe = 1'b1;
        if (tick && (q == 2'd1)) state_nx = S_ADDR;
      end
      S_ADDR: begin
        scl_oe = ~q[1];
        sda_oe = ~sh[7];
        if (slot_end && (bit_cnt == 3'd7)) state_nx = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        scl_oe = ~q[1];
        if (slot_end) begin
          if (ack_smp || (rem == '0)) state_nx = S_STOP;
          else if (rw_q)              state_nx = S_RD;
          else begin
            state_nx = S_WR;
            tx_ack   = 1'b1;
          end
        end
      end
      S_WR: begin
        scl_oe = ~q[1];
        sda_oe = ~sh[7];
        if (slot_end && (bit_cnt == 3'd7)) state_nx = S_WR_ACK;
      end
      S_WR_ACK: begin
        scl_oe = ~q[1];
        if (slot_end) begin
          if (ack_smp || (rem < LEN_W'(2))) state_nx = S_STOP;
          else begin
            state_nx = S_WR;
            tx_ack   = 1'b1;
          end
        end
      end
      S_RD: begin
        scl_oe = ~q[1];
        if (slot_end && (bit_cnt == 3'd7)) state_nx = S_RD_ACK;
      end
      S_RD_ACK: begin
        scl_oe = ~q[1];
        // rem still counts the byte just received, so >1 means more bytes follow
        sda_oe = (rem > LEN_W'(1));
        if (slot_end) state_nx = (rem < LEN_W'(2)) ? S_STOP : S_RD;
      end
      S_STOP: begin
        scl_oe = ~q[1];
        sda_oe = (q != 2'd3);
        if (slot_end) state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b0;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt     <= '0;
      q        <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      rem      <= '0;
      rw_q     <= 1'b0;
      ack_smp  <= 1'b0;
      ack_err  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      if (state == S_IDLE) qcnt <= '0;
      else                 qcnt <= tick ? '0 : qcnt + QW'(1);

      // q and bit_cnt restart at every state change so each phase begins on slot q0
      if ((state == S_IDLE) || (state == S_DONE)) begin
        q       <= '0;
        bit_cnt <= '0;
      end else if (tick) begin
        if (state_nx != state) begin
          q       <= '0;
          bit_cnt <= '0;
        end else begin
          q <= q + 2'd1;
          if (q == 2'd3) bit_cnt <= bit_cnt + 3'd1;
        end
      end

      if ((state == S_IDLE) && start) begin
        sh      <= {addr, rw};
        rw_q    <= rw;
        rem     <= len;
        ack_err <= 1'b0;
      end else if (tx_ack) begin
        sh <= tx_data;
      end else if (slot_end && ((state == S_ADDR) || (state == S_WR))) begin
        sh <= {sh[6:0], 1'b0};
      end else if (samp && (state == S_RD)) begin
        sh <= {sh[6:0], sda_i};
      end

      if (samp && ((state == S_ADDR_ACK) || (state == S_WR_ACK))) ack_smp <= sda_i;
      if (slot_end && ((state == S_ADDR_ACK) || (state == S_WR_ACK)) && ack_smp) ack_err <= 1'b1;
      if (slot_end && ((state == S_WR_ACK) || (state == S_RD_ACK)) && (rem != '0)) rem <= rem - LEN_W'(1);

      if (slot_end && (state == S_RD) && (bit_cnt == 3'd7)) begin
        rx_data  <= sh;
        rx_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_burst_master.sv
// Directed bench for i2c_burst_master: a table of transactions against a bit-level I2C slave model,
// plus hand-written reset-state and mid-read reset sequences.
module tb_i2c_burst_master;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned LEN_W   = 4;
  localparam int          NONE    = 99;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [6:0]       addr = '0;
  logic             rw = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [7:0]       tx_data = '0;
  logic             tx_ack, rx_valid, busy, done, ack_err, scl_oe, sda_oe, sda_i;
  logic [7:0]       rx_data;
  logic             s_pull = 1'b0;

  assign sda_i = ~(sda_oe | s_pull);

  i2c_burst_master #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .rw(rw), .len(len),
    .tx_data(tx_data), .tx_ack(tx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .done(done), .ack_err(ack_err), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  addr;
    logic        rw;
    logic [3:0]  len;
    int          nack_at;
    logic [31:0] wbytes;
    logic [31:0] rbytes;
    logic        exp_err;
    int          exp_tx;
    int          exp_rxn;
    logic [31:0] exp_rxw;
    logic [31:0] exp_log;
    int          exp_logn;
    logic [7:0]  exp_macks;
    int          exp_busy;
  } vec_t;

  vec_t vecs[5];

  int checks = 0;
  int failures = 0;

  int          cur_nack;
  logic [31:0] cur_w, cur_r;
  int          m_busy, m_done, m_tx, m_rxn;
  logic [31:0] m_rx;
  logic        tx_pend;

  logic        s_on = 1'b0, s_rd = 1'b0, s_mack = 1'b0;
  logic        s_prev_scl = 1'b1, s_prev_sda = 1'b1;
  int          s_cnt = 0, s_idx = 0, s_starts = 0, s_stops = 0, s_wcnt = 0;
  logic [7:0]  s_sh = '0, s_acks = '0;
  logic [31:0] s_wlog = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pick(input logic [31:0] w, input int k);
    logic [31:0] t;
    if (k < 0 || k > 3) return 8'h00;
    t = w >> (8 * (3 - k));
    return t[7:0];
  endfunction

  task automatic slave_step();
    logic scl_l, sda_l;
    logic [7:0] b;
    scl_l = ~scl_oe;
    sda_l = ~(sda_oe | s_pull);
    if (s_prev_scl && scl_l && s_prev_sda && !sda_l) begin
      s_on = 1'b1; s_cnt = 0; s_idx = 0; s_rd = 1'b0; s_sh = '0; s_pull = 1'b0;
      s_starts++;
    end else if (s_prev_scl && scl_l && !s_prev_sda && sda_l) begin
      s_on = 1'b0; s_pull = 1'b0;
      s_stops++;
    end else if (s_on && !s_prev_scl && scl_l) begin
      if (s_cnt < 8) s_sh = {s_sh[6:0], sda_l};
      else           s_mack = sda_l;
      s_cnt++;
    end else if (s_on && s_prev_scl && !scl_l) begin
      if (s_cnt == 8) begin
        if (s_idx == 0) s_rd = s_sh[0];
        if (s_idx == 0 || !s_rd) begin
          s_wlog = {s_wlog[23:0], s_sh};
          s_wcnt++;
          s_pull = (s_idx != cur_nack);
        end else begin
          s_pull = 1'b0;
        end
      end else if (s_cnt == 9) begin
        if (s_idx > 0 && s_rd) s_acks = {s_acks[6:0], s_mack};
        s_pull = 1'b0;
        // slave keeps sending only after an ACKed address or a master ACK
        if (s_rd && ((s_idx == 0 && cur_nack != 0) || (s_idx > 0 && !s_mack))) begin
          b = pick(cur_r, s_idx);
          s_pull = ~b[7];
        end
        s_idx++;
        s_cnt = 0;
      end else if (s_rd && s_idx > 0 && s_cnt >= 1 && s_cnt <= 7) begin
        b = pick(cur_r, s_idx - 1);
        s_pull = ~b[7 - s_cnt];
      end
    end
    s_prev_scl = scl_l;
    s_prev_sda = ~(sda_oe | s_pull);
  endtask

  task automatic monitor_step();
    if (tx_pend) begin
      tx_data = pick(cur_w, m_tx);
      tx_pend = 1'b0;
    end
    if (busy) m_busy++;
    if (done) m_done++;
    if (tx_ack) begin
      m_tx++;
      tx_pend = 1'b1;
    end
    if (rx_valid) begin
      m_rx = {m_rx[23:0], rx_data};
      m_rxn++;
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    slave_step();
    monitor_step();
  endtask

  task automatic begin_txn(input vec_t v);
    cur_nack = v.nack_at; cur_w = v.wbytes; cur_r = v.rbytes;
    m_busy = 0; m_done = 0; m_tx = 0; m_rxn = 0; m_rx = '0; tx_pend = 1'b0;
    s_starts = 0; s_stops = 0; s_wlog = '0; s_wcnt = 0; s_acks = '0;
    addr = v.addr; rw = v.rw; len = v.len; tx_data = pick(v.wbytes, 0);
    start = 1'b1;
    run_cycle();
    start = 1'b0;
    chk("busy_on_accept", busy, 1);
    chk("ack_err_cleared", ack_err, 0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    begin_txn(v);
    for (int c = 0; c < 3000 && m_done == 0; c++) begin
      if (c == 40) begin
        start = 1'b1; addr = 7'h7F; rw = ~v.rw; len = '1;
      end
      if (c == 41) start = 1'b0;
      run_cycle();
    end
    start = 1'b0;
    chk($sformatf("v%0d_done_seen", id), m_done, 1);
    for (int k = 0; k < 3; k++) run_cycle();
    chk($sformatf("v%0d_done_pulses", id), m_done, 1);
    chk($sformatf("v%0d_busy_cycles", id), m_busy, v.exp_busy);
    chk($sformatf("v%0d_busy_after", id), busy, 0);
    chk($sformatf("v%0d_ack_err", id), ack_err, v.exp_err);
    chk($sformatf("v%0d_tx_acks", id), m_tx, v.exp_tx);
    chk($sformatf("v%0d_rx_count", id), m_rxn, v.exp_rxn);
    chk($sformatf("v%0d_rx_bytes", id), m_rx, v.exp_rxw);
    chk($sformatf("v%0d_sda_bytes", id), s_wlog, v.exp_log);
    chk($sformatf("v%0d_sda_count", id), s_wcnt, v.exp_logn);
    chk($sformatf("v%0d_master_acks", id), s_acks, v.exp_macks);
    chk($sformatf("v%0d_start_cond", id), s_starts, 1);
    chk($sformatf("v%0d_stop_cond", id), s_stops, 1);
    chk($sformatf("v%0d_lines_idle", id), {scl_oe, sda_oe}, 0);
  endtask

  initial begin
    vecs[0] = '{7'h50, 1'b0, 4'd2, NONE, 32'hA53C0000, 32'h0, 1'b0, 2, 0, 32'h0,
                32'h00A0A53C, 3, 8'h00, 456};
    vecs[1] = '{7'h68, 1'b1, 4'd3, NONE, 32'h0, 32'h11223300, 1'b0, 0, 3, 32'h00112233,
                32'h000000D1, 1, 8'b001, 600};
    vecs[2] = '{7'h20, 1'b0, 4'd1, 0, 32'h77000000, 32'h0, 1'b1, 0, 0, 32'h0,
                32'h00000040, 1, 8'h00, 168};
    vecs[3] = '{7'h3A, 1'b0, 4'd0, NONE, 32'h0, 32'h0, 1'b0, 0, 0, 32'h0,
                32'h00000074, 1, 8'h00, 168};
    vecs[4] = '{7'h2B, 1'b0, 4'd4, 2, 32'h01020304, 32'h0, 1'b1, 2, 0, 32'h0,
                32'h00560102, 3, 8'h00, 456};

    for (int k = 0; k < 3; k++) run_cycle();
    chk("rst_lines", {scl_oe, sda_oe}, 0);
    chk("rst_status", {busy, done, tx_ack, rx_valid, ack_err}, 0);
    chk("rst_rx_data", rx_data, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) run_cycle();
    chk("idle_after_rst", {busy, scl_oe, sda_oe}, 0);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], i);
      for (int k = 0; k < 4; k++) run_cycle();
    end

    // reset during the second read byte, then a clean write must follow
    begin_txn(vecs[1]);
    for (int c = 0; c < 2000 && m_rxn == 0; c++) run_cycle();
    chk("rd_first_byte_seen", m_rxn, 1);
    chk("rd_first_byte_val", m_rx, 32'h11);
    for (int k = 0; k < 30; k++) run_cycle();
    chk("mid_rd_busy", busy, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_lines", {scl_oe, sda_oe}, 0);
    chk("rst_mid_status", {busy, done, rx_valid, ack_err}, 0);
    chk("rst_mid_rx_data", rx_data, 0);
    s_on = 1'b0; s_pull = 1'b0;
    for (int k = 0; k < 3; k++) run_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) run_cycle();
    chk("post_rst_idle", {busy, scl_oe, sda_oe}, 0);
    run_vec(vecs[0], 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
